// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the packet-atomic NoC arbiter.
// Holds the FSM state encoding, index-width helper and round-robin pick.
package noc_arb_pkg;

    // Widest requester vector rr_pick can handle.
    localparam int MAX_INPUTS = 32;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t IDLE   = 1'b0;
    localparam arb_state_t LOCKED = 1'b1;

    // Index width that stays legal (>= 1 bit) for a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot of the first set req bit at or after ptr, wrapping below n.
    function automatic logic [MAX_INPUTS-1:0] rr_pick(
        input logic [MAX_INPUTS-1:0] req,
        input int                    ptr,
        input int                    n
    );
        logic [MAX_INPUTS-1:0] pick;
        logic                  found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            if (!found && i < n && i >= ptr && req[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < MAX_INPUTS; i++) begin
            if (!found && i < n && i < ptr && req[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/noc_arb_obuf.sv
// Output FIFO for the packet arbiter: flit plus last flag per entry.
// Counter-based occupancy; head is registered, no push-to-pop bypass.
module noc_arb_obuf
    import noc_arb_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FLIT_WIDTH-1:0] push_flit,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [FLIT_WIDTH-1:0] head_flit,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [DEPTH-1:0][FLIT_WIDTH-1:0] flit_q, flit_d;
    logic [DEPTH-1:0]                 last_q, last_d;
    logic [AW-1:0]                    wptr_q, wptr_d;
    logic [AW-1:0]                    rptr_q, rptr_d;
    logic [CW-1:0]                    count_q, count_d;
    logic                             do_push;
    logic                             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head mux; an empty buffer presents zeros.
    always_comb begin
        head_flit = '0;
        head_last = 1'b0;
        if (!empty) begin
            head_flit = flit_q[rptr_q];
            head_last = last_q[rptr_q];
        end
    end

    // Next storage, wrapping pointers and occupancy.
    always_comb begin
        flit_d  = flit_q;
        last_d  = last_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            flit_d[wptr_q] = push_flit;
            last_d[wptr_q] = push_last;
            wptr_d = (wptr_q == LAST_SLOT) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == LAST_SLOT) ? '0 : rptr_q + 1'b1;
        end
        unique case (1'b1)
            do_push && !do_pop: count_d = count_q + 1'b1;
            !do_push && do_pop: count_d = count_q - 1'b1;
            default:            count_d = count_q;
        endcase
    end

    // Buffer state registers; reset drops every stored flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_q  <= '0;
            last_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            flit_q  <= flit_d;
            last_q  <= last_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/noc_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing one output among INPUTS streams.
// The owner keeps the output until its last flit is accepted.
module noc_pkt_arbiter
    import noc_arb_pkg::*;
#(
    parameter int FLIT_WIDTH   = 32,
    parameter int INPUTS       = 5,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INPUTS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [INPUTS-1:0]                  in_last,
    input  logic [INPUTS-1:0]                  in_valid,
    output logic [INPUTS-1:0]                  in_ready,
    output logic [FLIT_WIDTH-1:0]              out_flit,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [INPUTS-1:0]                  grant
);

    localparam int IW = idx_w(INPUTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(INPUTS - 1);

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         sel_q, sel_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [INPUTS-1:0]     grant_q, grant_d;
    logic [MAX_INPUTS-1:0] pick;
    logic [IW-1:0]         pick_idx;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  push;
    logic                  pop;
    logic                  sel_valid;
    logic                  sel_last;
    logic [FLIT_WIDTH-1:0] sel_flit;

    assign sel_valid = in_valid[sel_q];
    assign sel_last  = in_last[sel_q];
    assign sel_flit  = in_flit[sel_q];
    assign push      = (state_q == LOCKED) && sel_valid && !buf_full;
    assign pop       = !buf_empty && out_ready;
    assign out_valid = !buf_empty;
    assign grant     = grant_q;

    // Round-robin candidate and its index, used only while idle.
    always_comb begin
        pick     = rr_pick(MAX_INPUTS'(in_valid), int'(ptr_q), INPUTS);
        pick_idx = '0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    // Only the owner sees ready, and only while the buffer has room.
    always_comb begin
        in_ready = '0;
        if (state_q == LOCKED) in_ready[sel_q] = !buf_full;
    end

    // Lock on a winner when idle; release after its last flit is taken.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (1'b1)
            state_q == IDLE: begin
                if (|in_valid) begin
                    state_d = LOCKED;
                    sel_d   = pick_idx;
                    grant_d = pick[INPUTS-1:0];
                end
            end
            state_q == LOCKED: begin
                if (push && sel_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    noc_arb_obuf #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (BUFFER_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_flit (sel_flit),
        .push_last (sel_last),
        .pop       (pop),
        .head_flit (out_flit),
        .head_last (out_last),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule

// File: tb/tb_noc_pkt_arbiter.sv
// Randomized scoreboard bench for noc_pkt_arbiter.
// Reference model tracks owner, rr pointer and buffer occupancy as integers.
module tb_noc_pkt_arbiter;

    localparam int FW    = 32;
    localparam int N     = 5;
    localparam int DEPTH = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0][FW-1:0] in_flit = '0;
    logic [N-1:0]        in_last = '0;
    logic [N-1:0]        in_valid = '0;
    logic [N-1:0]        in_ready;
    logic [FW-1:0]       out_flit;
    logic                out_last;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [N-1:0]        grant;

    int checks = 0;
    int errors = 0;

    // Scoreboard of flits the model says were accepted, in order.
    logic [FW:0] exp_q[$];

    // Reference model state.
    int owner = -1;
    int ptr = 0;
    int occ = 0;
    bit model_on = 1'b0;
    bit rst_seen = 1'b0;

    // Driver state and knobs.
    int rem[N];
    logic [N-1:0] en = '1;
    int min_len = 2;
    int max_len = 2;
    int gap_pct = 0;
    int start_pct = 100;
    int ordy_pct = 100;

    // Grant order capture for the round-robin check.
    bit rr_rec = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] rr_seq[$];

    always #5 clk = ~clk;

    noc_pkt_arbiter #(
        .FLIT_WIDTH   (FW),
        .INPUTS       (N),
        .BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic present(input int i);
        in_valid[i] = 1'b1;
        in_flit[i]  = {8'(i), 24'($urandom)};
        in_last[i]  = (rem[i] == 1);
    endtask

    task automatic drive(input logic [N-1:0] hs);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                rem[i]--;
                in_valid[i] = 1'b0;
            end
            if (!in_valid[i]) begin
                if (rem[i] > 0) begin
                    if ($urandom_range(99) >= gap_pct) present(i);
                end else if (en[i] && $urandom_range(99) < start_pct) begin
                    rem[i] = $urandom_range(max_len, min_len);
                    present(i);
                end
            end
        end
        out_ready = ($urandom_range(99) < ordy_pct);
    endtask

    // One cycle: compare at negedge, advance model, drive after posedge.
    task automatic step();
        logic [N-1:0] hs;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_rdy;
        int push;
        int pop;
        bit found;
        @(negedge clk);
        exp_grant = '0;
        exp_rdy   = '0;
        if (owner >= 0) begin
            exp_grant[owner] = 1'b1;
            exp_rdy[owner]   = (occ < DEPTH);
        end
        if (model_on) begin
            chk("grant", 64'(grant), 64'(exp_grant));
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(occ > 0));
            if (rst_seen) begin
                chk("rst_out_flit", 64'(out_flit), 64'(0));
                chk("rst_out_last", 64'(out_last), 64'(0));
            end
        end
        if (rr_rec && grant != '0 && prev_grant == '0) rr_seq.push_back(grant);
        prev_grant = grant;
        hs = in_valid & in_ready;
        rst_seen = rst;
        if (rst) begin
            owner = -1;
            ptr   = 0;
            occ   = 0;
            exp_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            push = 0;
            pop  = (occ > 0 && out_ready) ? 1 : 0;
            if (owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && in_valid[(ptr + k) % N]) begin
                        owner = (ptr + k) % N;
                        found = 1'b1;
                    end
                end
            end else if (in_valid[owner] && occ < DEPTH) begin
                exp_q.push_back({in_last[owner], in_flit[owner]});
                push = 1;
                if (in_last[owner]) begin
                    ptr   = (owner + 1) % N;
                    owner = -1;
                end
            end
            occ = occ + push - pop;
        end
        @(posedge clk);
        #1;
        drive(hs);
    endtask

    // Output monitor: head must match the oldest predicted flit.
    always @(negedge clk) begin
        if (model_on && !rst && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=%h expected=none t=%0t",
                         {out_last, out_flit}, $time);
            end else begin
                chk("out_data", 64'({out_last, out_flit}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int cyc;
        logic [N-1:0] want;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset held 3 cycles with every input requesting.
        rst = 1'b1;
        drive('0);
        rr_rec = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // All inputs stream 2-flit packets back to back.
        repeat (40) step();
        rr_rec = 1'b0;
        chk("rr_count_ge6", 64'(rr_seq.size() >= 6), 64'(1));
        for (int k = 0; k < 6 && k < rr_seq.size(); k++) begin
            want = '0;
            want[k % N] = 1'b1;
            chk("rr_order", 64'(rr_seq[k]), 64'(want));
        end

        // Single-flit packets from inputs 1 and 3.
        en = 5'b01010;
        min_len = 1;
        max_len = 1;
        repeat (30) step();

        // Backpressure: downstream stalls, then drains.
        en = '1;
        min_len = 1;
        max_len = 4;
        ordy_pct = 0;
        repeat (12) step();
        ordy_pct = 100;
        repeat (12) step();

        // Random traffic with gaps, stalls and occasional resets.
        gap_pct = 30;
        start_pct = 40;
        ordy_pct = 70;
        for (cyc = 0; cyc < 2000; cyc++) begin
            step();
            rst = (cyc % 300 == 150);
        end
        rst = 1'b0;

        // Drain everything still in flight.
        gap_pct = 0;
        start_pct = 0;
        ordy_pct = 100;
        cyc = 0;
        while (cyc < 300 && !(owner < 0 && occ == 0 && in_valid == '0)) begin
            step();
            cyc++;
        end
        chk("drain_done", 64'(cyc < 300), 64'(1));
        step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
